// File: rtl/arquitetura_robot_pkg.sv
// Shared definitions for the robot-link command port: register map, status
// bit layout, serializer states and frame geometry.
package arquitetura_robot_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 16;

  localparam int BITS_PER_BYTE  = 8;
  localparam int BITS_PER_FRAME = 10;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/arquitetura_cmd_fifo.sv
// Show-ahead synchronous FIFO for command words; the caller never pushes
// while full nor pops while empty.
module arquitetura_cmd_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/arquitetura_wr_robot_cmd.sv
// Avalon-MM command port: buffers 32-bit words and shifts each out as four
// 8N1 bytes, LSB first, on a registered TX line.
module arquitetura_wr_robot_cmd
  import arquitetura_robot_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        tx
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  tx_state_t     state, state_nxt;
  logic [31:0]   fifo_dout, shift_reg, shift_nxt, status_word;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop, push_req;
  logic [15:0]   div_reg, bit_cnt, cnt_nxt, div_load;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [1:0]    byte_idx, byte_idx_nxt;
  logic          tx_q, tx_nxt, overflow, bit_end;
  logic          unused_read;

  // readdata is refreshed every cycle, so the strobe carries no information
  assign unused_read = read;

  function automatic logic [15:0] div_clamp(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  assign push_req  = write && (address == ADDR_DATA);
  assign fifo_push = push_req && !fifo_full;

  arquitetura_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32),
    .CW     (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (writedata),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      div_reg  <= 16'(DEFAULT_DIV);
    end else begin
      if (push_req && fifo_full)
        overflow <= 1'b1;
      else if (write && (address == ADDR_STATUS) && writedata[STAT_OVF])
        overflow <= 1'b0;
      if (write && (address == ADDR_DIV))
        div_reg <= writedata[15:0];
    end
  end

  always_comb begin
    status_word                        = '0;
    status_word[STAT_EMPTY]            = fifo_empty;
    status_word[STAT_FULL]             = fifo_full;
    status_word[STAT_BUSY]             = (state != ST_IDLE);
    status_word[STAT_OVF]              = overflow;
    status_word[STAT_CNT_LSB +: 4]     = 4'(fifo_count);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_STATUS: readdata <= status_word;
        ADDR_DIV:    readdata <= {16'd0, div_reg};
        default:     readdata <= '0;
      endcase
    end
  end

  // Each bit period reloads the counter from the live divisor, so a DIV
  // write only affects bits that start after it lands.
  assign div_load = div_clamp(div_reg) - 16'd1;
  assign bit_end  = (bit_cnt == 16'd0);

  always_comb begin
    state_nxt    = state;
    tx_nxt       = tx_q;
    cnt_nxt      = bit_end ? bit_cnt : bit_cnt - 16'd1;
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    shift_nxt    = shift_reg;
    fifo_pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_nxt    = fifo_dout;
          byte_idx_nxt = 2'd0;
          tx_nxt       = 1'b0;
          cnt_nxt      = div_load;
          state_nxt    = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_nxt      = shift_reg[0];
          bit_idx_nxt = 3'd0;
          cnt_nxt     = div_load;
          state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          // Shifting every data bit leaves the next byte in shift_reg[7:0].
          shift_nxt = shift_reg >> 1;
          cnt_nxt   = div_load;
          if (bit_idx == 3'(BITS_PER_BYTE - 1)) begin
            tx_nxt    = 1'b1;
            state_nxt = ST_STOP;
          end else begin
            tx_nxt      = shift_reg[1];
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_nxt = div_load;
          if (byte_idx != 2'(BYTES_PER_WORD - 1)) begin
            byte_idx_nxt = byte_idx + 2'd1;
            tx_nxt       = 1'b0;
            state_nxt    = ST_START;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx_q     <= 1'b1;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_nxt;
      tx_q     <= tx_nxt;
      bit_cnt  <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift_reg <= shift_nxt;
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_arquitetura_wr_robot_cmd.sv
// Directed plus randomized bench for the robot command port; expected TX
// waveforms come from an 8N1 frame model driven by the register writes.
module tb_arquitetura_wr_robot_cmd;
  import arquitetura_robot_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        tx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  arquitetura_wr_robot_cmd #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (434)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick();
    d       = readdata;
    read    = 1'b0;
  endtask

  // Line level of frame bit f of a word: 10 bits per byte, start=0,
  // eight data bits LSB first, stop=1, bytes in ascending order.
  function automatic logic frame_bit(input logic [31:0] w, input int f);
    int b = f / BITS_PER_FRAME;
    int p = f % BITS_PER_FRAME;
    if (p == 0) return 1'b0;
    if (p == BITS_PER_FRAME - 1) return 1'b1;
    return w[b * 8 + p - 1];
  endfunction

  // Called on the first cycle of the start bit; returns on the cycle after
  // the last stop bit. Optionally rewrites DIV during sample chg_at.
  task automatic run_frame(input string tag, input logic [31:0] w, input int div,
                           input int chg_at, input int new_div);
    int f   = 0;
    int k   = 0;
    int dv  = (div == 0) ? 1 : div;
    int rem = dv;
    while (f < BYTES_PER_WORD * BITS_PER_FRAME && k < 20000) begin
      check($sformatf("%s_tx_k%0d", tag, k), 32'(tx), 32'(frame_bit(w, f)));
      if (k == chg_at) begin
        address   = ADDR_DIV;
        writedata = 32'(new_div);
        write     = 1'b1;
      end
      tick();
      write = 1'b0;
      if (k == chg_at) dv = (new_div == 0) ? 1 : new_div;
      k++;
      rem--;
      if (rem == 0) begin
        f++;
        rem = dv;
      end
    end
  endtask

  logic [31:0] d;
  logic [31:0] w;
  logic [31:0] words [10];
  int          div;
  int          c0;

  initial begin
    reset     = 1'b1;
    write     = 1'b0;
    read      = 1'b0;
    address   = 2'd0;
    writedata = '0;
    repeat (3) tick();
    check("tx_in_reset", 32'(tx), 32'd1);
    check("rd_in_reset", readdata, 32'd0);
    reset = 1'b0;

    bus_read(ADDR_STATUS, d); check("status_after_reset", d, 32'h0000_0001);
    bus_read(ADDR_DIV, d);    check("div_after_reset", d, 32'd434);
    check("tx_idle_after_reset", 32'(tx), 32'd1);
    bus_read(2'd3, d);        check("addr3_read", d, 32'd0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(ADDR_DIV, d);    check("addr3_write_div", d, 32'd434);
    bus_read(ADDR_STATUS, d); check("addr3_write_status", d, 32'h0000_0001);

    // directed word, DIV=4
    bus_write(ADDR_DIV, 32'd4);
    bus_read(ADDR_DIV, d);    check("div_write4", d, 32'd4);
    bus_write(ADDR_DATA, 32'hA5C3_0F81);
    tick();
    run_frame("word_a5c30f81", 32'hA5C3_0F81, 4, -1, 0);
    check("tx_idle_after_word", 32'(tx), 32'd1);
    bus_read(ADDR_STATUS, d); check("status_after_word", d, 32'h0000_0001);

    // random words with random divisors (0 treated as 1)
    for (int i = 0; i < 4; i++) begin
      div = $urandom_range(0, 5);
      w   = $urandom;
      bus_write(ADDR_DIV, 32'(div));
      bus_write(ADDR_DATA, w);
      tick();
      run_frame($sformatf("rand%0d", i), w, div, -1, 0);
      bus_read(ADDR_STATUS, d); check($sformatf("rand%0d_status", i), d, 32'h0000_0001);
    end

    // DIV=0 stored as 0, runs at one cycle per bit
    bus_write(ADDR_DIV, 32'd0);
    bus_read(ADDR_DIV, d);    check("div_zero_readback", d, 32'd0);
    bus_write(ADDR_DATA, 32'h0000_00FF);
    tick();
    run_frame("div0_ff", 32'h0000_00FF, 0, -1, 0);
    check("div0_tx_idle", 32'(tx), 32'd1);

    // back-to-back pushes: first word popped a cycle after its push, so
    // nine fit, the tenth overflows
    bus_write(ADDR_DIV, 32'd4);
    for (int i = 0; i < 10; i++) begin
      words[i] = $urandom;
      bus_write(ADDR_DATA, words[i]);
      if (i == 0) c0 = cyc;
    end
    bus_read(ADDR_STATUS, d);   check("status_overflow", d, 32'h0008_000E);
    bus_write(ADDR_STATUS, 32'h7);
    bus_read(ADDR_STATUS, d);   check("ovf_kept_no_bit3", d, 32'h0008_000E);
    bus_write(ADDR_STATUS, 32'h8);
    bus_read(ADDR_STATUS, d);   check("ovf_cleared", d, 32'h0008_0006);
    while (cyc < c0 + 161) tick();
    for (int i = 1; i < 9; i++) begin
      check($sformatf("gap_before_w%0d", i), 32'(tx), 32'd1);
      tick();
      run_frame($sformatf("drain_w%0d", i), words[i], 4, -1, 0);
    end
    check("gap_after_drain", 32'(tx), 32'd1);
    bus_read(ADDR_STATUS, d);   check("status_drained", d, 32'h0000_0001);
    repeat (20) tick();
    check("no_tenth_word", 32'(tx), 32'd1);

    // divisor change during data bit 0: that bit keeps 4 cycles
    bus_write(ADDR_DIV, 32'd4);
    w = $urandom;
    bus_write(ADDR_DATA, w);
    tick();
    run_frame("div_change", w, 4, 6, 8);
    bus_read(ADDR_STATUS, d);   check("div_change_status", d, 32'h0000_0001);
    bus_read(ADDR_DIV, d);      check("div_change_readback", d, 32'd8);

    // reset in the middle of byte 2 with another word queued
    bus_write(ADDR_DIV, 32'd2);
    w = $urandom;
    bus_write(ADDR_DATA, w);
    bus_write(ADDR_DATA, $urandom);
    repeat (49) tick();
    check("pre_reset_tx", 32'(tx), 32'(frame_bit(w, 24)));
    reset = 1'b1;
    #1;
    check("tx_async_reset", 32'(tx), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    bus_read(ADDR_STATUS, d);   check("status_after_midreset", d, 32'h0000_0001);
    bus_read(ADDR_DIV, d);      check("div_after_midreset", d, 32'd434);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("no_residual_%0d", i), 32'(tx), 32'd1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
